// File: rtl/run_mon_pkg.sv
// Shared types for the end-of-program run monitor.
// Run states, termination causes and the mailbox pass value.
package run_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOOP    = 3'd4,
    ST_TIMEOUT = 3'd5
  } status_t;

  localparam int TOHOST_PASS = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over enable; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != '1)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Passive end-of-program monitor for the single-cycle core.
// Detects tohost, halt, self-loop and timeout; keeps run stats.
module cpu_run_monitor
  import run_mon_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 32,
  parameter logic [DATA_W-1:0] HALT_INSTR  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 10'h3FF,
  parameter int                LOOP_N      = 4,
  parameter int                TIMEOUT     = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddata_w,
  input  logic              d_w,
  input  logic              d_r,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  instrs,
  output logic [CNT_W-1:0]  dreads,
  output logic [CNT_W-1:0]  dwrites,
  output logic [DATA_W-1:0] tohost
);

  localparam int LW = $clog2(LOOP_N + 2);
  localparam logic [LW-1:0] LOOP_LIM = LW'(LOOP_N);

  // A timeout beyond the counter range fires once cycles saturates.
  localparam logic [63:0] CMAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0] TO64 = 64'(TIMEOUT);
  localparam logic [63:0] TLIM = (TO64 > CMAX) ? CMAX : TO64;
  localparam logic [CNT_W-1:0] TO_LIM = TLIM[CNT_W-1:0];

  state_t              state_q, state_d;
  status_t             status_q, status_d;
  logic [DATA_W-1:0]   tohost_q, tohost_d;
  logic [ADDR_W-1:0]   iaddr_q;
  logic [LW-1:0]       loop_q, loop_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                run;
  logic                launch;
  logic                hit_tohost;
  logic                hit_halt;
  logic                hit_loop;
  logic                hit_to;
  logic [CNT_W-1:0]    cyc_nxt;
  logic [LW-1:0]       loop_nxt;

  assign run    = (state_q == RUN);
  assign launch = start && !run;

  assign cyc_nxt = (cycles == '1) ? cycles : cycles + CNT_W'(1);

  // cycles is still zero during the first RUN cycle.
  assign loop_nxt = (cycles != '0 && iaddr == iaddr_q) ?
                    loop_q + LW'(1) : '0;

  assign hit_tohost = d_w && (daddr == TOHOST_ADDR);
  assign hit_halt   = (idata == HALT_INSTR);
  assign hit_loop   = (LOOP_N != 0) && (loop_nxt == LOOP_LIM);
  assign hit_to     = (TIMEOUT != 0) && (cyc_nxt == TO_LIM);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    tohost_d = tohost_q;
    loop_d   = loop_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (launch) begin
      state_d  = RUN;
      status_d = ST_NONE;
      tohost_d = '0;
      loop_d   = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (run) begin
      loop_d = loop_nxt;
      if (hit_tohost || hit_halt || hit_loop || hit_to) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      if (hit_tohost) begin
        tohost_d = ddata_w;
        status_d = (ddata_w == DATA_W'(TOHOST_PASS)) ?
                   ST_PASS : ST_FAIL;
      end else if (hit_halt)
        status_d = ST_HALT;
      else if (hit_loop)
        status_d = ST_LOOP;
      else if (hit_to)
        status_d = ST_TIMEOUT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      status_q <= ST_NONE;
      tohost_q <= '0;
      iaddr_q  <= '0;
      loop_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      tohost_q <= tohost_d;
      iaddr_q  <= iaddr;
      loop_q   <= loop_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .CLK (CLK),
    .RST (RST),
    .clr (launch),
    .en  (run),
    .q   (cycles)
  );

  sat_counter #(.W(CNT_W)) u_instrs (
    .CLK (CLK),
    .RST (RST),
    .clr (launch),
    .en  (run && !hit_halt),
    .q   (instrs)
  );

  sat_counter #(.W(CNT_W)) u_dreads (
    .CLK (CLK),
    .RST (RST),
    .clr (launch),
    .en  (run && d_r),
    .q   (dreads)
  );

  sat_counter #(.W(CNT_W)) u_dwrites (
    .CLK (CLK),
    .RST (RST),
    .clr (launch),
    .en  (run && d_w),
    .q   (dwrites)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign status = status_q;
  assign tohost = tohost_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: default instance plus two
// narrow-counter instances for the timeout and saturation cases.
module tb_cpu_run_monitor;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  iaddr = '0;
  logic [31:0] idata = NOP;
  logic [9:0]  daddr = '0;
  logic [31:0] ddata_w = '0;
  logic        d_w = 1'b0;
  logic        d_r = 1'b0;

  logic        busy0, done0;
  logic [2:0]  status0;
  logic [31:0] cycles0, instrs0, dreads0, dwrites0, tohost0;

  logic        busyA, doneA;
  logic [2:0]  statusA;
  logic [3:0]  cyclesA, instrsA, dreadsA, dwritesA;
  logic [31:0] tohostA;

  logic        busyB, doneB;
  logic [2:0]  statusB;
  logic [3:0]  cyclesB, instrsB, dreadsB, dwritesB;
  logic [31:0] tohostB;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cpu_run_monitor u_dut (
    .CLK(CLK), .RST(RST), .start(start), .iaddr(iaddr), .idata(idata),
    .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
    .busy(busy0), .done(done0), .status(status0), .cycles(cycles0),
    .instrs(instrs0), .dreads(dreads0), .dwrites(dwrites0),
    .tohost(tohost0)
  );

  cpu_run_monitor #(.CNT_W(4), .TIMEOUT(20)) u_to20 (
    .CLK(CLK), .RST(RST), .start(start), .iaddr(iaddr), .idata(idata),
    .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
    .busy(busyA), .done(doneA), .status(statusA), .cycles(cyclesA),
    .instrs(instrsA), .dreads(dreadsA), .dwrites(dwritesA),
    .tohost(tohostA)
  );

  cpu_run_monitor #(.CNT_W(4), .TIMEOUT(12)) u_to12 (
    .CLK(CLK), .RST(RST), .start(start), .iaddr(iaddr), .idata(idata),
    .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
    .busy(busyB), .done(doneB), .status(statusB), .cycles(cyclesB),
    .instrs(instrsB), .dreads(dreadsB), .dwrites(dwritesB),
    .tohost(tohostB)
  );

  task automatic step(input logic [9:0] ia, input logic [31:0] id);
    iaddr = ia;
    idata = id;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(10'h3F0, NOP);
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(10'h000, NOP);
    step(10'h001, NOP);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b exp=0", done0); end
    checks++; if (status0 !== 3'd0) begin errors++; $display("FAIL rst_status got=%0d exp=0", status0); end
    checks++; if (cycles0 !== 32'd0) begin errors++; $display("FAIL rst_cycles got=%0d exp=0", cycles0); end
    checks++; if (tohost0 !== 32'd0) begin errors++; $display("FAIL rst_tohost got=%0h exp=0", tohost0); end
    RST = 1'b0;
    step(10'h002, NOP);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0b exp=0", busy0); end
  endtask

  task automatic test_reset_midrun();
    do_start();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL start_busy got=%0b exp=1", busy0); end
    for (int i = 0; i < 50; i++) step(10'h100 + 10'(i), NOP);
    checks++; if (cycles0 !== 32'd50) begin errors++; $display("FAIL mid_cycles got=%0d exp=50", cycles0); end
    RST = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%0b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL mrst_done got=%0b exp=0", done0); end
    checks++; if (cycles0 !== 32'd0) begin errors++; $display("FAIL mrst_cycles got=%0d exp=0", cycles0); end
    checks++; if (instrs0 !== 32'd0) begin errors++; $display("FAIL mrst_instrs got=%0d exp=0", instrs0); end
    checks++; if (status0 !== 3'd0) begin errors++; $display("FAIL mrst_status got=%0d exp=0", status0); end
    step(10'h000, NOP);
    RST = 1'b0;
    step(10'h001, NOP);
  endtask

  task automatic test_halt();
    do_start();
    checks++; if (cycles0 !== 32'd0) begin errors++; $display("FAIL halt_clr got=%0d exp=0", cycles0); end
    for (int i = 0; i < 7; i++) step(10'h100 + 10'(i), NOP);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL halt_early got=%0b exp=0", done0); end
    step(10'h107, 32'h0);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL halt_done got=%0b exp=1", done0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL halt_busy got=%0b exp=0", busy0); end
    checks++; if (status0 !== 3'd1) begin errors++; $display("FAIL halt_status got=%0d exp=1", status0); end
    checks++; if (cycles0 !== 32'd8) begin errors++; $display("FAIL halt_cycles got=%0d exp=8", cycles0); end
    checks++; if (instrs0 !== 32'd7) begin errors++; $display("FAIL halt_instrs got=%0d exp=7", instrs0); end
    step(10'h108, NOP);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL halt_hold got=%0b exp=1", done0); end
    checks++; if (cycles0 !== 32'd8) begin errors++; $display("FAIL halt_frozen got=%0d exp=8", cycles0); end
  endtask

  task automatic test_tohost(input logic [31:0] val, input logic [2:0] exp_st);
    do_start();
    checks++; if (tohost0 !== 32'd0) begin errors++; $display("FAIL th_clr got=%0h exp=0", tohost0); end
    checks++; if (status0 !== 3'd0) begin errors++; $display("FAIL th_st_clr got=%0d exp=0", status0); end
    for (int i = 0; i < 4; i++) step(10'h100 + 10'(i), NOP);
    d_w = 1'b1;
    daddr = 10'h3FF;
    ddata_w = val;
    step(10'h104, 32'h0);
    d_w = 1'b0;
    daddr = 10'h000;
    ddata_w = '0;
    checks++; if (status0 !== exp_st) begin errors++; $display("FAIL th_status got=%0d exp=%0d", status0, exp_st); end
    checks++; if (tohost0 !== val) begin errors++; $display("FAIL th_value got=%0h exp=%0h", tohost0, val); end
    checks++; if (cycles0 !== 32'd5) begin errors++; $display("FAIL th_cycles got=%0d exp=5", cycles0); end
    checks++; if (dwrites0 !== 32'd1) begin errors++; $display("FAIL th_dwrites got=%0d exp=1", dwrites0); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL th_done got=%0b exp=1", done0); end
  endtask

  task automatic test_loop();
    do_start();
    step(10'h200, NOP);
    step(10'h201, NOP);
    for (int i = 0; i < 4; i++) step(10'h020, NOP);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL loop_early got=%0b exp=0", done0); end
    step(10'h020, NOP);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL loop_done got=%0b exp=1", done0); end
    checks++; if (status0 !== 3'd4) begin errors++; $display("FAIL loop_status got=%0d exp=4", status0); end
    checks++; if (cycles0 !== 32'd7) begin errors++; $display("FAIL loop_cycles got=%0d exp=7", cycles0); end
    do_start();
    step(10'h200, NOP);
    step(10'h201, NOP);
    for (int i = 0; i < 3; i++) step(10'h020, NOP);
    for (int i = 1; i < 6; i++) step(10'h020 + 10'(i), NOP);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL loop3_done got=%0b exp=0", done0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL loop3_busy got=%0b exp=1", busy0); end
    checks++; if (cycles0 !== 32'd10) begin errors++; $display("FAIL loop3_cycles got=%0d exp=10", cycles0); end
    step(10'h030, 32'h0);
    checks++; if (status0 !== 3'd1) begin errors++; $display("FAIL loop3_halt got=%0d exp=1", status0); end
  endtask

  task automatic test_timeout();
    RST = 1'b1;
    step(10'h000, NOP);
    RST = 1'b0;
    d_r = 1'b1;
    do_start();
    for (int i = 0; i < 12; i++) step(10'h300 + 10'(i), NOP);
    checks++; if (doneB !== 1'b1) begin errors++; $display("FAIL to12_done got=%0b exp=1", doneB); end
    checks++; if (statusB !== 3'd5) begin errors++; $display("FAIL to12_status got=%0d exp=5", statusB); end
    checks++; if (cyclesB !== 4'd12) begin errors++; $display("FAIL to12_cycles got=%0d exp=12", cyclesB); end
    checks++; if (dreadsB !== 4'd12) begin errors++; $display("FAIL to12_dreads got=%0d exp=12", dreadsB); end
    checks++; if (doneA !== 1'b0) begin errors++; $display("FAIL to20_early got=%0b exp=0", doneA); end
    checks++; if (cyclesA !== 4'd12) begin errors++; $display("FAIL to20_c12 got=%0d exp=12", cyclesA); end
    for (int i = 12; i < 15; i++) step(10'h300 + 10'(i), NOP);
    checks++; if (doneA !== 1'b1) begin errors++; $display("FAIL to20_done got=%0b exp=1", doneA); end
    checks++; if (statusA !== 3'd5) begin errors++; $display("FAIL to20_status got=%0d exp=5", statusA); end
    checks++; if (cyclesA !== 4'd15) begin errors++; $display("FAIL to20_cycles got=%0d exp=15", cyclesA); end
    checks++; if (dreadsA !== 4'd15) begin errors++; $display("FAIL to20_dreads got=%0d exp=15", dreadsA); end
    checks++; if (instrsA !== 4'd15) begin errors++; $display("FAIL to20_instrs got=%0d exp=15", instrsA); end
    for (int i = 15; i < 18; i++) step(10'h300 + 10'(i), NOP);
    checks++; if (cyclesA !== 4'd15) begin errors++; $display("FAIL to20_frozen got=%0d exp=15", cyclesA); end
    checks++; if (cyclesB !== 4'd12) begin errors++; $display("FAIL to12_frozen got=%0d exp=12", cyclesB); end
    checks++; if (cycles0 !== 32'd18) begin errors++; $display("FAIL def_running got=%0d exp=18", cycles0); end
  endtask

  task automatic test_restart();
    d_r = 1'b0;
    start = 1'b1;
    step(10'h320, NOP);
    start = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL runstart_busy got=%0b exp=1", busy0); end
    checks++; if (cycles0 !== 32'd19) begin errors++; $display("FAIL runstart_cycles got=%0d exp=19", cycles0); end
    checks++; if (dreads0 !== 32'd18) begin errors++; $display("FAIL runstart_dreads got=%0d exp=18", dreads0); end
    step(10'h321, 32'h0);
    checks++; if (cycles0 !== 32'd20) begin errors++; $display("FAIL rs_halt_cycles got=%0d exp=20", cycles0); end
    checks++; if (instrs0 !== 32'd19) begin errors++; $display("FAIL rs_halt_instrs got=%0d exp=19", instrs0); end
    start = 1'b1;
    step(10'h322, 32'h0);
    start = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL restart_busy got=%0b exp=1", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL restart_done got=%0b exp=0", done0); end
    checks++; if (status0 !== 3'd0) begin errors++; $display("FAIL restart_status got=%0d exp=0", status0); end
    checks++; if (cycles0 !== 32'd0) begin errors++; $display("FAIL restart_cycles got=%0d exp=0", cycles0); end
    checks++; if (instrs0 !== 32'd0) begin errors++; $display("FAIL restart_instrs got=%0d exp=0", instrs0); end
    checks++; if (dreads0 !== 32'd0) begin errors++; $display("FAIL restart_dreads got=%0d exp=0", dreads0); end
    step(10'h323, NOP);
    checks++; if (cycles0 !== 32'd1) begin errors++; $display("FAIL restart_c1 got=%0d exp=1", cycles0); end
    checks++; if (instrs0 !== 32'd1) begin errors++; $display("FAIL restart_i1 got=%0d exp=1", instrs0); end
    step(10'h324, 32'h0);
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_halt();
    test_tohost(32'h0000_0001, 3'd2);
    test_tohost(32'h0000_DEAD, 3'd3);
    test_loop();
    test_timeout();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable end-of-program monitor for the single-cycle RISC-V core. It snoops the core's instruction and data-memory buses, detects program completion by one of four configurable criteria, and exposes run statistics. It is a parametrised, synthesizable generalisation of "stop when instruction is zero": it adds tohost pass/fail, self-loop detection, timeout and counters. It sits beside `CPU_Core` in simulation tops and FPGA wrappers; it never drives the core.

## Interface

- `ADDR_W`, 10, IMEM/DMEM word-address width
- `DATA_W`, 32, instruction/data width
- `CNT_W`, 32, width of every statistics counter
- `HALT_INSTR`, 32'h0000_0000, instruction word that ends a run
- `TOHOST_ADDR`, 10'h3FF, DMEM address of the pass/fail mailbox
- `LOOP_N`, 4, consecutive unchanged-`iaddr` cycles that count as a self-loop; 0 disables
- `TIMEOUT`, 100000, maximum run cycles; 0 disables

- `CLK` in 1: clock, rising edge
- `RST` in 1: asynchronous, active-high reset
- `start` in 1: begin a run; clears all counters
- `iaddr` in ADDR_W: core instruction address
- `idata` in DATA_W: fetched instruction
- `daddr` in ADDR_W: core data address
- `ddata_w` in DATA_W: core write data
- `d_w` in 1: DMEM write strobe
- `d_r` in 1: DMEM read strobe
- `busy` out 1: state is RUN
- `done` out 1: state is DONE
- `status` out 3: termination cause (see Operation)
- `cycles` out CNT_W: RUN cycles
- `instrs` out CNT_W: RUN cycles with `idata != HALT_INSTR`
- `dreads` out CNT_W: RUN cycles with `d_r`
- `dwrites` out CNT_W: RUN cycles with `d_w`
- `tohost` out DATA_W: value captured on the mailbox write

## Operation

- States:
  - IDLE: after reset.
  - RUN.
  - DONE.
- `status` codes:
  - NONE=0
  - HALT=1
  - PASS=2
  - FAIL=3
  - LOOP=4
  - TIMEOUT=5
- IDLE→RUN: on `start`. On the same edge, all counters, `tohost` and the loop counter clear and `status` goes to NONE.
- DONE→RUN: on `start`, with identical clearing.
- `start` in RUN: ignored.
- In RUN, every cycle:
  - Each counter increments by its qualifier.
  - The first RUN cycle counts.
  - The terminating cycle counts.
- Counters saturate at 2^CNT_W−1; they never wrap.
- Termination checks apply in RUN only. The first true check wins, in this priority:
  1. `d_w && daddr==TOHOST_ADDR`: `tohost`←`ddata_w`. `status`←PASS if `ddata_w==1`, else FAIL.
  2. `idata==HALT_INSTR`: `status`←HALT.
  3. Loop count reaches LOOP_N (LOOP_N≠0): `status`←LOOP.
  4. Post-increment `cycles` value equals TIMEOUT (TIMEOUT≠0): `status`←TIMEOUT.
- Any termination moves RUN→DONE.
- Loop counter:
  - A registered `iaddr_q` is loaded every cycle.
  - In RUN, the counter increments when `iaddr==iaddr_q` and clears otherwise.
  - The comparison is suppressed in the first RUN cycle.
- Reset, including mid-run: state IDLE, all outputs 0, `status` NONE.

## Timing

- All outputs are registered.
- `busy` rises on the edge that samples `start`.
- `done` and `status` update on the edge that samples the terminating condition, i.e. zero cycles after the condition is sampled.
- `done` holds until `start` or `RST`.
- Counter values are final in the same cycle `done` rises, and stay frozen in DONE.
- A halt instruction fetched at RUN cycle k gives `cycles==k` and `instrs==k−1`.
- Simultaneous `start` and termination in DONE: `start` wins.

## Structure

- `run_mon_pkg` holds:
  - `state_t` (IDLE/RUN/DONE).
  - `status_t` (3-bit enum above).
  - `TOHOST_PASS` = 1.
- Sub-module `sat_counter`:
  - Parameter `W`.
  - Ports: `CLK`, `RST`, `clr`, `en`, `q`.
  - Saturating increment.
  - Instantiated four times.
- FSM, loop detector and termination priority stay in `cpu_run_monitor`.

## Test plan

- Reset mid-run (RUN, `cycles`=50, assert `RST`) → `busy`=0, `done`=0, all counters 0, `status`=NONE immediately.
- `start`, feed 7 nonzero instructions then `idata`=0 → `done`=1, `status`=HALT, `cycles`=8, `instrs`=7.
- `start`, on cycle 5 `d_w`=1, `daddr`=10'h3FF, `ddata_w`=1, same cycle `idata`=0 → PASS (priority), `tohost`=1. Repeat with `ddata_w`=32'hDEAD → FAIL, `tohost`=32'hDEAD.
- `start`, `iaddr` held at 10'h020 from cycle 3, LOOP_N=4 → LOOP with `cycles`=7. Hold for only 3 cycles, then change `iaddr` → no termination.
- TIMEOUT=20, CNT_W=4, nonzero instructions, `d_r` every cycle → TIMEOUT at `cycles`=15 (saturated, never wraps). With TIMEOUT=12 → stops at `cycles`=12, `dreads`=12.
- In DONE, pulse `start` → counters 0 on the next edge, `busy`=1. `start` pulsed during RUN → no effect on counters.
